// File: rtl/led_mode_sequencer.sv
// Mode selector for the LED pattern engine: a debounced button steps the mode,
// an optional auto-cycle advances it after a fixed dwell, and every change emits a restart pulse.
module led_mode_sequencer #(
    parameter int DEB_CYCLES   = 4,
    parameter int DWELL_CYCLES = 64,
    parameter int NUM_MODES    = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_next,
    input  logic       sw_auto,
    output logic [1:0] mode,
    output logic       pat_rst,
    output logic       auto_active
);
    localparam int DEB_W   = $clog2(DEB_CYCLES + 1);
    localparam int DWELL_W = $clog2(DWELL_CYCLES);

    localparam logic [DEB_W-1:0]   DEB_LAST   = DEB_W'(DEB_CYCLES - 1);
    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL_CYCLES - 1);
    localparam logic [1:0]         MODE_LAST  = 2'(NUM_MODES - 1);

    logic               r_btn_s1;
    logic               r_btn_s2;
    logic               r_auto_s1;
    logic               r_auto_s2;
    logic               r_deb_lvl;
    logic [DEB_W-1:0]   r_deb_cnt;
    logic               r_next_evt;
    logic [DWELL_W-1:0] r_dwell;
    logic [1:0]         r_mode;
    logic               r_pat_rst;
    logic               w_adv;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_btn_s1  <= 1'b0;
            r_btn_s2  <= 1'b0;
            r_auto_s1 <= 1'b0;
            r_auto_s2 <= 1'b0;
        end else begin
            r_btn_s1  <= btn_next;
            r_btn_s2  <= r_btn_s1;
            r_auto_s1 <= sw_auto;
            r_auto_s2 <= r_auto_s1;
        end
    end

    // Level change accepted after DEB_CYCLES stable samples; only a rising accept fires an event.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_deb_lvl  <= 1'b0;
            r_deb_cnt  <= '0;
            r_next_evt <= 1'b0;
        end else begin
            r_next_evt <= 1'b0;
            if (r_btn_s2 == r_deb_lvl) begin
                r_deb_cnt <= '0;
            end else if (r_deb_cnt == DEB_LAST) begin
                r_deb_lvl  <= r_btn_s2;
                r_deb_cnt  <= '0;
                r_next_evt <= r_btn_s2;
            end else begin
                r_deb_cnt <= r_deb_cnt + 1'b1;
            end
        end
    end

    // A button event and a dwell expiry in the same cycle merge into a single advance.
    assign w_adv = r_next_evt | (r_auto_s2 & (r_dwell == DWELL_LAST));

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_dwell   <= '0;
            r_mode    <= 2'd0;
            r_pat_rst <= 1'b1;
        end else begin
            if (!r_auto_s2 || w_adv) begin
                r_dwell <= '0;
            end else begin
                r_dwell <= r_dwell + 1'b1;
            end
            if (w_adv) begin
                r_mode    <= (r_mode == MODE_LAST) ? 2'd0 : r_mode + 2'd1;
                r_pat_rst <= 1'b1;
            end else begin
                r_pat_rst <= 1'b0;
            end
        end
    end

    assign mode        = r_mode;
    assign pat_rst     = r_pat_rst;
    assign auto_active = r_auto_s2;

endmodule

// File: tb/tb_led_mode_sequencer.sv
// Directed bench for led_mode_sequencer: reset, presses with wrap, bounce rejection,
// auto-cycling, button/dwell collision and reset in the middle of a dwell period.
module tb_led_mode_sequencer;
  logic       clk = 1'b0;
  logic       reset;
  logic       btn_next;
  logic       sw_auto;
  logic [1:0] mode;
  logic       pat_rst;
  logic       auto_active;

  int n_checks = 0;
  int n_errors = 0;
  logic [1:0] exp_mode = 2'd0;

  led_mode_sequencer #(
    .DEB_CYCLES(4),
    .DWELL_CYCLES(64),
    .NUM_MODES(3)
  ) dut (
    .clk(clk),
    .reset(reset),
    .btn_next(btn_next),
    .sw_auto(sw_auto),
    .mode(mode),
    .pat_rst(pat_rst),
    .auto_active(auto_active)
  );

  // clock
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // one rising edge, then settle so outputs are sampled away from the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // n edges during which nothing may change: no restart pulse, mode stays put
  task automatic run_quiet(input int n, input string tag);
    int bad_rst = 0;
    int bad_mode = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (pat_rst !== 1'b0) bad_rst++;
      if (mode !== exp_mode) bad_mode++;
    end
    check_val({tag, "_quiet_prst"}, bad_rst, 0);
    check_val({tag, "_quiet_mode"}, bad_mode, 0);
  endtask

  // advance must land exactly on the n-th edge from now
  task automatic expect_adv(input int n, input logic [1:0] new_mode, input string tag);
    if (n > 1) run_quiet(n - 1, tag);
    tick();
    check_val({tag, "_mode"}, mode, new_mode);
    check_val({tag, "_prst"}, pat_rst, 1);
    exp_mode = new_mode;
  endtask

  // clean 20-cycle press: advance on the 7th edge after the first high sample
  task automatic press(input logic [1:0] new_mode, input string tag);
    btn_next = 1'b1;
    expect_adv(7, new_mode, tag);
    run_quiet(13, {tag, "_hold"});
    btn_next = 1'b0;
    run_quiet(12, {tag, "_rel"});
  endtask

  int bounce_runs[15] = '{3, 1, 3, 2, 1, 1, 2, 3, 3, 1, 3, 2, 3, 1, 1};

  initial begin
    reset    = 1'b0;
    btn_next = 1'b0;
    sw_auto  = 1'b0;

    for (int i = 0; i < 3; i++) begin
      tick();
      check_val("rst_mode", mode, 0);
      check_val("rst_prst", pat_rst, 1);
      check_val("rst_auto", auto_active, 0);
    end
    reset = 1'b1;
    tick();
    check_val("rel_prst", pat_rst, 0);
    check_val("rel_mode", mode, 0);
    check_val("rel_auto", auto_active, 0);
    run_quiet(5, "idle");

    press(2'd1, "press1");
    press(2'd2, "press2");
    press(2'd0, "press3_wrap");
    press(2'd1, "press4");

    for (int r = 0; r < 15; r++) begin
      btn_next = (r % 2 == 0);
      for (int c = 0; c < bounce_runs[r]; c++) begin
        tick();
        check_val("bounce_prst", pat_rst, 0);
      end
    end
    btn_next = 1'b0;
    run_quiet(20, "bounce");
    check_val("bounce_mode", mode, 1);

    press(2'd2, "press5");
    press(2'd0, "press6_wrap");

    sw_auto = 1'b1;
    tick();
    check_val("auto_sync1", auto_active, 0);
    tick();
    check_val("auto_sync2", auto_active, 1);
    expect_adv(64, 2'd1, "auto_a1");
    expect_adv(64, 2'd2, "auto_a2");
    expect_adv(64, 2'd0, "auto_a3_wrap");
    expect_adv(64, 2'd1, "auto_a4");

    run_quiet(57, "coll_pre");
    btn_next = 1'b1;
    expect_adv(7, 2'd2, "collision");
    btn_next = 1'b0;
    expect_adv(64, 2'd0, "coll_next");

    sw_auto = 1'b0;
    tick();
    tick();
    check_val("auto_off", auto_active, 0);
    run_quiet(500, "manual_hold");

    sw_auto = 1'b1;
    tick();
    tick();
    check_val("auto_on2", auto_active, 1);
    expect_adv(64, 2'd1, "auto_b1");
    expect_adv(64, 2'd2, "auto_b2");
    run_quiet(40, "mid_dwell");
    reset = 1'b0;
    tick();
    check_val("midrst_mode", mode, 0);
    check_val("midrst_prst", pat_rst, 1);
    check_val("midrst_auto", auto_active, 0);
    exp_mode = 2'd0;
    reset = 1'b1;
    tick();
    check_val("midrel_prst", pat_rst, 0);
    check_val("midrel_auto", auto_active, 0);
    tick();
    check_val("midrel_auto2", auto_active, 1);
    expect_adv(64, 2'd1, "midrel_adv");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
